fetcher_icache: RTL and testbench
=================================

// Module: fetcher_icache
// PURPOSE
// Per-core instruction fetcher with a small direct-mapped instruction cache.
// Upstream consumer of the read-only program-memory controller; occupies one consumer slot on it.
// Services the core's FETCH phase in 1 cycle on a hit; on a miss issues one valid/ready read and fills the line.
// Hands the instruction to the decoder.
// PARAMETERS
// PROGRAM_ADDR_BITS  8   PC / program memory address width
// PROGRAM_DATA_BITS  16  instruction width
// CACHE_LINES        8   direct-mapped lines, one instruction each; power of 2, >=2
// CNT_BITS           16  width of hit/miss statistics counters
// PORTS
// clk               in   1   clock, rising edge
// reset             in   1   asynchronous, active-low reset
// core_state        in   3   core phase; FETCH=3'b001, DECODE=3'b010 (gpu_pkg)
// current_pc        in   PROGRAM_ADDR_BITS  address of instruction to fetch
// flush             in   1   invalidate all lines (kernel launch); single-cycle pulse
// mem_read_valid    out  1   read request to program-memory controller
// mem_read_address  out  PROGRAM_ADDR_BITS  request address
// mem_read_ready    in   1   controller response strobe (1 cycle)
// mem_read_data     in   PROGRAM_DATA_BITS  response data, valid with mem_read_ready
// fetcher_state     out  3   IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010
// instruction       out  PROGRAM_DATA_BITS  fetched instruction, stable while FETCHED
// hit_count         out  CNT_BITS  saturating count of cache hits
// miss_count        out  CNT_BITS  saturating count of cache misses
// BEHAVIOUR
// - Reset (reset=0, async): fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0.
//   Also hit/miss counters=0, all line valid bits=0, poison=0. An in-flight request is abandoned.
// - Index = current_pc[$clog2(CACHE_LINES)-1:0]; tag = remaining upper PC bits.
// - IDLE with core_state==FETCH:
//   - Hit (valid & tag match): instruction<=line data, hit_count++, ->FETCHED (fetcher_state shows FETCHED next cycle).
//   - Miss: mem_read_valid<=1, mem_read_address<=current_pc, miss_count++, ->FETCHING.
// - FETCHING: hold valid/address until mem_read_ready=1. Then, in that cycle:
//   - instruction<=mem_read_data, mem_read_valid<=0, ->FETCHED.
//   - Line written (data, tag, valid=1) unless poison=1. Valid drops the cycle after ready, which releases the controller channel.
// - FETCHED: hold instruction; ->IDLE when core_state==DECODE. Other core_state values hold FETCHED.
// - IDLE with core_state!=FETCH: no action.
// - flush=1: all valid bits cleared that edge.
//   - Flush in FETCHING, or coincident with mem_read_ready: set poison. The pending fill still delivers instruction but is not installed. Poison clears on leaving FETCHING.
//   - Flush coincident with an IDLE lookup: lookup uses pre-flush contents; a hit is honoured.
// - Counters saturate at all-ones; never wrap. A flush does not clear them.
// - Exactly one outstanding request; no new lookup until FETCHED->IDLE.
// - current_pc is sampled only in IDLE; changes during FETCHING/FETCHED are ignored.
// STRUCTURE
// gpu_pkg: core_state encodings (FETCH, DECODE), fetcher_state localparams/typedef.
// Sub-module icache_line_array: tag/data/valid storage.
//   - Combinational read port (index -> valid, tag, data).
//   - Synchronous write port.
//   - Global clear for flush and for reset.
// Top: 3-state FSM, poison flag, saturating counters.
// TESTING
// 1 Cold miss: reset, pc=0x05, core_state=FETCH.
//   -> mem_read_valid=1 addr=0x05 next cycle.
//   -> Memory returns 0xA1B2 after 3 cycles: instruction=0xA1B2, FETCHED, miss_count=1.
// 2 Hit: after test 1, DECODE then FETCH pc=0x05.
//   -> FETCHED 1 cycle later, no mem_read_valid, instruction=0xA1B2, hit_count=1.
// 3 Conflict: pc=0x0D (same index as 0x05 with 8 lines) -> miss, fill 0x1111.
//   -> Then pc=0x05 -> miss again, miss_count increments.
// 4 Flush mid-miss: flush during FETCHING for pc=0x20.
//   -> Instruction delivered; re-fetch of 0x20 misses (line not installed).
// 5 Reset mid-FETCHING: reset=0 asynchronously.
//   -> mem_read_valid=0 immediately, state IDLE, counters 0; next fetch of prior hit PC misses.
// 6 Saturation: CNT_BITS=4, 20 hits -> hit_count=4'hF, holds.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared encodings for the core phase seen by the fetcher and for the fetcher's own state.
package gpu_pkg;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/fetcher_icache_line_array.sv
// Direct-mapped line storage: combinational lookup, synchronous fill, global invalidate.
module fetcher_icache_line_array #(
  parameter int LINES     = 8,
  parameter int IDX_BITS  = 3,
  parameter int TAG_BITS  = 5,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_BITS-1:0]  rd_index,
  output logic                 rd_valid,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [DATA_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 clear
);

  logic [LINES-1:0]     valid_bits;
  logic [TAG_BITS-1:0]  tags  [LINES];
  logic [DATA_BITS-1:0] datas [LINES];

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = datas[rd_index];

  // Valid bits: cleared by reset or flush; flush wins over a same-edge fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_bits <= '0;
    end else if (clear) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
    end
  end

  // Tag and data payload; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      datas[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/fetcher_icache.sv
// Instruction fetcher with a direct-mapped cache in front of the program-memory controller.
module fetcher_icache
  import gpu_pkg::*;
#(
  parameter int PROGRAM_ADDR_BITS = 8,
  parameter int PROGRAM_DATA_BITS = 16,
  parameter int CACHE_LINES       = 8,
  parameter int CNT_BITS          = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   core_state,
  input  logic [PROGRAM_ADDR_BITS-1:0] current_pc,
  input  logic                         flush,
  output logic                         mem_read_valid,
  output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                   fetcher_state,
  output logic [PROGRAM_DATA_BITS-1:0] instruction,
  output logic [CNT_BITS-1:0]          hit_count,
  output logic [CNT_BITS-1:0]          miss_count
);

  localparam int IDX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS = PROGRAM_ADDR_BITS - IDX_BITS;

  fetcher_state_t state;
  logic poison;

  logic                         lk_valid;
  logic [TAG_BITS-1:0]          lk_tag;
  logic [PROGRAM_DATA_BITS-1:0] lk_data;
  logic                         lk_hit;
  logic                         fill_en;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + {{(CNT_BITS-1){1'b0}}, 1'b1};
  endfunction

  assign lk_hit = lk_valid && (lk_tag == current_pc[PROGRAM_ADDR_BITS-1:IDX_BITS]);

  // The fill uses the registered request address, so PC changes during the miss are harmless.
  // A flush on the response edge also blocks installation of the stale line.
  assign fill_en = (state == FETCHER_FETCHING) && mem_read_ready && !poison && !flush;

  assign fetcher_state = state;

  fetcher_icache_line_array #(
    .LINES     (CACHE_LINES),
    .IDX_BITS  (IDX_BITS),
    .TAG_BITS  (TAG_BITS),
    .DATA_BITS (PROGRAM_DATA_BITS)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .rd_index (current_pc[IDX_BITS-1:0]),
    .rd_valid (lk_valid),
    .rd_tag   (lk_tag),
    .rd_data  (lk_data),
    .wr_en    (fill_en),
    .wr_index (mem_read_address[IDX_BITS-1:0]),
    .wr_tag   (mem_read_address[PROGRAM_ADDR_BITS-1:IDX_BITS]),
    .wr_data  (mem_read_data),
    .clear    (flush)
  );

  // Fetch FSM with registered request, instruction, poison flag and statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      poison           <= 1'b0;
    end else begin
      case (state)
        FETCHER_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lk_hit) begin
              instruction <= lk_data;
              hit_count   <= sat_inc(hit_count);
              state       <= FETCHER_FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              miss_count       <= sat_inc(miss_count);
              state            <= FETCHER_FETCHING;
            end
          end
        end
        FETCHER_FETCHING: begin
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            poison         <= 1'b0;
            state          <= FETCHER_FETCHED;
          end else if (flush) begin
            poison <= 1'b1;
          end
        end
        FETCHER_FETCHED: begin
          if (core_state == CORE_DECODE) begin
            state <= FETCHER_IDLE;
          end
        end
        default: begin
          state <= FETCHER_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher_icache.sv
// Scoreboard bench for fetcher_icache: stimulus pushes expected requests/fetches, a monitor checks them.
module tb_fetcher_icache;

  localparam logic [2:0] FETCH  = 3'b001;
  localparam logic [2:0] DECODE = 3'b010;
  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_FETCHED = 3'b010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  core_state = 3'b000;
  logic [7:0]  current_pc = 8'h00;
  logic        flush = 1'b0;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [3:0]  hit_count;
  logic [3:0]  miss_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          is_req;
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [3:0]  hits;
    logic [3:0]  misses;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] prog [256];

  fetcher_icache #(
    .PROGRAM_ADDR_BITS (8),
    .PROGRAM_DATA_BITS (16),
    .CACHE_LINES       (8),
    .CNT_BITS          (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .flush            (flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Program memory responder: answers three cycles after the request, gives up if it is withdrawn.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_read_valid) begin
        logic [7:0] a;
        bit alive;
        a = mem_read_address;
        alive = 1'b1;
        repeat (2) begin
          @(negedge clk);
          if (!mem_read_valid) alive = 1'b0;
        end
        if (alive && mem_read_valid) begin
          mem_read_ready = 1'b1;
          mem_read_data  = prog[a];
          @(negedge clk);
          mem_read_ready = 1'b0;
          mem_read_data  = 16'h0000;
        end
      end
    end
  end

  // Monitor: a request edge or entry into FETCHED pops the next expectation.
  initial begin
    logic       prev_valid;
    logic [2:0] prev_state;
    prev_valid = 1'b0;
    prev_state = S_IDLE;
    forever begin
      @(negedge clk);
      if (mem_read_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_request", 32'(mem_read_address), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("request_kind", 32'(1), 32'(e.is_req));
          check("request_addr", 32'(mem_read_address), 32'(e.addr));
        end
      end
      if (fetcher_state == S_FETCHED && prev_state != S_FETCHED) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetched", 32'(instruction), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("fetched_kind", 32'(0), 32'(e.is_req));
          check("instruction", 32'(instruction), 32'(e.instr));
          check("hit_count", 32'(hit_count), 32'(e.hits));
          check("miss_count", 32'(miss_count), 32'(e.misses));
        end
      end
      prev_valid = mem_read_valid;
      prev_state = fetcher_state;
    end
  end

  // One fetch transaction; flush_at selects the cycle (0 = lookup edge) to pulse flush, -1 for none.
  task automatic do_fetch(input logic [7:0] pc, input bit miss, input logic [15:0] instr,
                          input logic [3:0] hits, input logic [3:0] misses, input int flush_at);
    int cycles;
    if (miss) exp_q.push_back('{1'b1, pc, 16'h0, 4'h0, 4'h0});
    exp_q.push_back('{1'b0, 8'h00, instr, hits, misses});
    core_state = FETCH;
    current_pc = pc;
    flush = (flush_at == 0);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      flush = (cycles == flush_at);
      if (cycles == 1 && miss) check("miss_request_next_cycle", 32'(mem_read_valid), 32'(1));
      if (fetcher_state == S_FETCHED) break;
      if (cycles > 40) begin
        check("fetch_timeout", 32'(fetcher_state), 32'(S_FETCHED));
        break;
      end
    end
    if (!miss) check("hit_latency", 32'(cycles), 32'(1));
    flush = 1'b0;
    core_state = DECODE;
    @(negedge clk);
    core_state = 3'b000;
    check("back_to_idle", 32'(fetcher_state), 32'(S_IDLE));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 16'h0;
    prog[8'h05] = 16'hA1B2;
    prog[8'h0D] = 16'h1111;
    prog[8'h20] = 16'h2020;

    repeat (2) @(negedge clk);
    check("rst_state", 32'(fetcher_state), 32'(S_IDLE));
    check("rst_valid", 32'(mem_read_valid), 32'(0));
    check("rst_addr", 32'(mem_read_address), 32'(0));
    check("rst_instr", 32'(instruction), 32'(0));
    check("rst_hits", 32'(hit_count), 32'(0));
    check("rst_misses", 32'(miss_count), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // cold miss, hit, conflict
    do_fetch(8'h05, 1'b1, 16'hA1B2, 4'd0, 4'd1, -1);
    do_fetch(8'h05, 1'b0, 16'hA1B2, 4'd1, 4'd1, -1);
    do_fetch(8'h0D, 1'b1, 16'h1111, 4'd1, 4'd2, -1);
    do_fetch(8'h05, 1'b1, 16'hA1B2, 4'd1, 4'd3, -1);

    // flush during FETCHING: delivered but not installed
    do_fetch(8'h20, 1'b1, 16'h2020, 4'd1, 4'd4, 1);
    do_fetch(8'h20, 1'b1, 16'h2020, 4'd1, 4'd5, -1);
    do_fetch(8'h20, 1'b0, 16'h2020, 4'd2, 4'd5, -1);
    // flush coincident with lookup: hit honoured, then everything is gone
    do_fetch(8'h20, 1'b0, 16'h2020, 4'd3, 4'd5, 0);
    do_fetch(8'h20, 1'b1, 16'h2020, 4'd3, 4'd6, -1);
    do_fetch(8'h05, 1'b1, 16'hA1B2, 4'd3, 4'd7, -1);
    do_fetch(8'h05, 1'b0, 16'hA1B2, 4'd4, 4'd7, -1);

    // asynchronous reset while a miss is outstanding
    exp_q.push_back('{1'b1, 8'h0D, 16'h0, 4'h0, 4'h0});
    core_state = FETCH;
    current_pc = 8'h0D;
    repeat (2) @(negedge clk);
    check("mid_fetch_valid", 32'(mem_read_valid), 32'(1));
    #2 reset = 1'b0;
    #1;
    check("async_valid_drop", 32'(mem_read_valid), 32'(0));
    check("async_state", 32'(fetcher_state), 32'(S_IDLE));
    check("async_hits", 32'(hit_count), 32'(0));
    check("async_misses", 32'(miss_count), 32'(0));
    core_state = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_fetch(8'h05, 1'b1, 16'hA1B2, 4'd0, 4'd1, -1);

    // hit counter saturation
    for (int i = 1; i <= 20; i++) begin
      do_fetch(8'h05, 1'b0, 16'hA1B2, (i < 15) ? 4'(i) : 4'hF, 4'd1, -1);
    end
    check("sat_hold", 32'(hit_count), 32'hF);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so a stuck DUT still produces a summary.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
